// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states and datapath widths for the
// iterative shift units.
package alu_pkg;

    localparam int WORD_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : alu_pkg

// File: rtl/sll_seq_if.sv
// Request/result bundle between the execute-stage controller (master)
// and the iterative left shifter (slave).
interface sll_seq_if #(
    parameter int WIDTH = alu_pkg::WORD_W
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             lost;

    // The controller raises start and stalls on busy until done pulses.
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  out,
        input  lost
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output out,
        output lost
    );

endinterface : sll_seq_if

// File: rtl/sll_seq.sv
// Iterative shift-left-logical unit: one bit per clock, done pulses with the
// result held on out, lost flags any 1 bit pushed past the MSB.
module sll_seq #(
    parameter int WIDTH   = alu_pkg::WORD_W,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic      clk,
    input  logic      reset,
    sll_seq_if.slave  bus
);

    import alu_pkg::*;

    state_t             state, state_next;
    logic [WIDTH-1:0]   acc, acc_next;
    logic [SHAMT_W-1:0] cnt, cnt_next;
    logic               lost_q, lost_next;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = bus.b[SHAMT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            lost_q <= 1'b0;
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            cnt    <= cnt_next;
            lost_q <= lost_next;
        end
    end

    // Start is only looked at in IDLE, so requests during SHIFT/DONE are dropped.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        lost_next  = lost_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_next   = bus.a;
                    cnt_next   = shamt;
                    lost_next  = 1'b0;
                    state_next = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_next  = {acc[WIDTH-2:0], 1'b0};
                lost_next = lost_q | acc[WIDTH-1];
                cnt_next  = cnt - 1'b1;
                if (cnt == SHAMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.out  = acc;
    assign bus.lost = lost_q;

endmodule : sll_seq

// File: tb/tb_sll_seq.sv
// Self-checking bench for sll_seq: directed vector table plus hand-written
// back-to-back and mid-operation reset sequences.
module tb_sll_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_lost;
        int          exp_lat;
    } vec_t;

    logic clk;
    logic reset;
    int   check_count;
    int   pass_count;

    sll_seq_if #(.WIDTH(32)) bus ();

    sll_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Accepts one operation and follows it to done; a/b are scrambled after
    // the accepting edge to show they are no longer needed.
    task automatic applyStimulus(input logic [31:0] a_in, input logic [31:0] b_in,
                                 input logic [31:0] exp_out, input logic exp_lost,
                                 input int exp_lat, input string tag);
        int cycles;
        int busy_cycles;
        @(negedge clk);
        bus.a     = a_in;
        bus.b     = b_in;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        cycles      = 1;
        busy_cycles = 0;
        while (!bus.done && cycles < 40) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (bus.busy) busy_cycles++;
        checkOutput({tag, " done_seen"}, 32'(bus.done), 32'd1);
        checkOutput({tag, " latency"}, 32'(cycles), 32'(exp_lat));
        checkOutput({tag, " busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
        checkOutput({tag, " out"}, bus.out, exp_out);
        checkOutput({tag, " lost"}, 32'(bus.lost), 32'(exp_lost));
        @(posedge clk);
        #1;
        checkOutput({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " idle_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " out_held"}, bus.out, exp_out);
        checkOutput({tag, " lost_held"}, 32'(bus.lost), 32'(exp_lost));
    endtask

    vec_t vecs[7];

    initial begin
        check_count = 0;
        pass_count  = 0;

        vecs[0] = '{32'h0000_0001, 32'd4,         32'h0000_0010, 1'b0, 5};
        vecs[1] = '{32'h8000_0001, 32'd1,         32'h0000_0002, 1'b1, 2};
        vecs[2] = '{32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1'b0, 1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32};
        vecs[4] = '{32'h1234_5678, 32'h0000_0024, 32'h2345_6780, 1'b1, 5};
        vecs[5] = '{32'h00F0_0000, 32'd8,         32'hF000_0000, 1'b0, 9};
        vecs[6] = '{32'h0F00_0000, 32'd8,         32'h0000_0000, 1'b1, 9};

        // Reset held two cycles with start asserted must not launch anything.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'h0000_0005;
        bus.b     = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset out",  bus.out,          32'd0);
            checkOutput("reset busy", 32'(bus.busy),    32'd0);
            checkOutput("reset done", 32'(bus.done),    32'd0);
            checkOutput("reset lost", 32'(bus.lost),    32'd0);
        end
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_lost,
                          vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Start held high: accepts every 4 cycles, done on cycles 2, 6, 10.
        @(negedge clk);
        bus.a     = 32'h1;
        bus.b     = 32'd2;
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("b2b done k%0d", k), 32'(bus.done),
                        32'((k % 4) == 2));
            if ((k % 4) == 2) begin
                checkOutput($sformatf("b2b out k%0d", k), bus.out, 32'h4);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("b2b drained busy", 32'(bus.busy), 32'd0);

        // Reset during the third SHIFT cycle aborts without a done pulse.
        @(negedge clk);
        bus.a     = 32'h1;
        bus.b     = 32'd10;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("abort loaded out", bus.out, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort out",  bus.out,       32'd0);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort lost", 32'(bus.lost), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int stray_done;
            stray_done = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk);
                #1;
                if (bus.done) stray_done++;
            end
            checkOutput("abort no_done", 32'(stray_done), 32'd0);
        end
        applyStimulus(32'h3, 32'd1, 32'h6, 1'b0, 2, "after_abort");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule : tb_sll_seq

// File: doc/sll_seq.md
# sll_seq

Iterative shift-left-logical unit for the processor's ALU; the left-direction counterpart of the single-step arithmetic right shifter. It accepts an operand and a 5-bit shift amount, shifts one bit per clock, and pulses `done` with the result. It sits beside the combinational ALU ops and is started by the execute-stage controller, which stalls on `busy`.

## Interface

- WIDTH, 32, operand/result width
- SHAMT_W, 5, shift-amount width (log2 WIDTH)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge of clk
- start  in  1  request; accepted only when state is IDLE
- a  in  WIDTH  operand to shift
- b  in  WIDTH  shift amount taken from b[SHAMT_W-1:0]; upper bits ignored
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; result valid on `out`
- out  out  WIDTH  shift result (accumulator register)
- lost  out  1  high if any 1 bit was shifted out of bit WIDTH-1 during the operation

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE: on edge with start=1, load acc<=a, cnt<=b[4:0], lost<=0; next state DONE if b[4:0]==0, else SHIFT. start=0: hold.
- SHIFT: each edge acc<=acc<<1 (zero fill), lost<=lost|acc[WIDTH-1], cnt<=cnt-1; when cnt==1 next state DONE.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- start while busy (SHIFT or DONE) is ignored; no queuing.
- out = acc; stable from the done cycle until the next accepted start, at which point it shows the new `a`.
- lost is valid with done and held with out.
- Shift amount 31 is the maximum; no shift-by-32 case exists.

## Timing

- Reset: state IDLE, acc 0, cnt 0, lost 0 → out 0, busy 0, done 0.
- start sampled high at edge N with shift amount s: busy high from cycle after edge N; done high in the cycle after edge N+s; IDLE after edge N+s+1.
- Latency start→done = s+1 cycles (s=0: 1 cycle; s=31: 32 cycles).
- Back-to-back: next start accepted at earliest on edge N+s+2 (first IDLE cycle).
- done and busy are both high in the DONE cycle.
- reset mid-operation (SHIFT or DONE): abort; no done pulse; all registers to reset values on that edge.
- a/b need only be valid on the accepting edge; later changes have no effect.

## Structure

- Shared package `alu_pkg`: state enum {IDLE, SHIFT, DONE}, constants WORD_W=32, SHAMT_W=5.
- Single flat module; no sub-module. Three registers (state, acc, cnt) plus lost. Outputs drive directly from registers or state decode; no combinational path from inputs to outputs.

## Test plan

- Reset: hold reset 2 cycles with start=1 → out=0, busy=0, done=0, lost=0; no operation starts.
- a=0x0000_0001, b=4, start 1 cycle → done exactly 5 cycles after accept, out=0x0000_0010, lost=0, busy high 5 cycles.
- a=0x8000_0001, b=1 → done after 2 cycles, out=0x0000_0002, lost=1; b=0 with a=0xDEAD_BEEF → done after 1 cycle, out=0xDEAD_BEEF, lost=0.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF (shamt 31) → done after 32 cycles, out=0x8000_0000, lost=1.
- start held high continuously with a=1, b=2 → operations accepted every 4 cycles, done pulses spaced 4 apart, each out=0x4; start pulses during busy produce no extra done.
- a=0x1, b=10, assert reset on 3rd SHIFT cycle → no done pulse, out=0, busy=0 next cycle; fresh start a=0x3,b=1 → out=0x6 after 2 cycles.
